// File: rtl/frame_buf_writer_if.sv
// rtl/frame_buf_writer_if.sv - raster pixel stream between pixel source and frame-buffer writer
interface frame_buf_writer_if #(
   parameter int DATA_W = 12
) ();
   logic              valid;
   logic [DATA_W-1:0] data;
   logic              sof;
   logic              ready;

   modport master (output valid, output data, output sof, input ready);
   modport slave  (input valid, input data, input sof, output ready);
endinterface

// File: rtl/frame_buf_writer.sv
// rtl/frame_buf_writer.sv - captures one raster-ordered frame into the frame-buffer BRAM write port
module frame_buf_writer #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int DATA_W = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   frame_buf_writer_if.slave   pix,
   output logic                wr_en,
   output logic [16:0]         wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic                busy,
   output logic                frame_done,
   output logic                sof_err
);

   localparam logic [8:0] X_LAST = 9'(H_RES - 1);
   localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, DONE} state_t;

   state_t      state, state_nxt;
   logic [8:0]  x;
   logic [7:0]  y;
   logic [16:0] addr;     // next linear address, kept in lockstep with x/y
   logic        accept;

   assign accept = pix.valid && pix.ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and state-decoded handshake/status outputs
   always_comb begin
      state_nxt  = state;
      pix.ready  = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = WAIT_SOF;
         end
         WAIT_SOF: begin
            pix.ready = 1'b1;
            busy      = 1'b1;
            if (accept && pix.sof) state_nxt = WRITE;
         end
         WRITE: begin
            pix.ready = 1'b1;
            busy      = 1'b1;
            // a resync SOF wins over end-of-frame, so only non-SOF pixels can finish the frame
            if (accept && !pix.sof && x == X_LAST && y == Y_LAST) state_nxt = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Raster counters and registered BRAM write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x       <= '0;
         y       <= '0;
         addr    <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         sof_err <= 1'b0;
      end else begin
         wr_en   <= 1'b0;
         sof_err <= 1'b0;
         if (state == IDLE) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
         end else if ((state == WAIT_SOF || state == WRITE) && accept) begin
            if (pix.sof) begin
               // SOF always restarts the raster at pixel (0,0)
               wr_en   <= 1'b1;
               wr_addr <= '0;
               wr_data <= pix.data;
               sof_err <= (state == WRITE);
               x       <= 9'd1;
               y       <= '0;
               addr    <= 17'd1;
            end else if (state == WRITE) begin
               wr_en   <= 1'b1;
               wr_addr <= addr;
               wr_data <= pix.data;
               addr    <= addr + 17'd1;
               if (x == X_LAST) begin
                  x <= '0;
                  y <= y + 8'd1;
               end else begin
                  x <= x + 9'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_buf_writer.sv
// tb/tb_frame_buf_writer.sv - randomized self-checking bench for frame_buf_writer against a pixel-count reference model
module tb_frame_buf_writer;
   localparam int H = 20;
   localparam int V = 6;
   localparam int N = H * V;
   localparam int DW = 12;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           wr_en;
   logic [16:0]    wr_addr;
   logic [DW-1:0]  wr_data;
   logic           busy;
   logic           frame_done;
   logic           sof_err;

   frame_buf_writer_if #(.DATA_W(DW)) pix ();

   frame_buf_writer #(.H_RES(H), .V_RES(V), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pix        (pix.slave),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .frame_done (frame_done),
      .sof_err    (sof_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: a capture is armed, synced once an SOF is seen, and counts pixels since SOF
   bit m_busy, m_synced, m_done, m_acc;
   int m_count;
   int wr_cnt, fd_cnt, se_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_synced = 0; m_done = 0; m_acc = 0; m_count = 0;
   endtask

   task automatic step(input bit st, input bit v, input bit s, input logic [DW-1:0] d);
      bit e_wr, e_se;
      int e_addr;
      start = st; pix.valid = v; pix.sof = s; pix.data = d;
      m_acc = v && m_busy && !m_done;
      e_wr = 0; e_se = 0; e_addr = 0;
      @(posedge clk);
      #1;
      if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
         if (st) begin m_busy = 1; m_synced = 0; end
      end else if (m_acc) begin
         if (s) begin
            e_wr = 1; e_addr = 0; e_se = m_synced; m_synced = 1; m_count = 1;
         end else if (m_synced) begin
            e_wr = 1; e_addr = m_count; m_count++;
            if (m_count == N) m_done = 1;
         end
      end
      if (wr_en === 1'b1) wr_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (sof_err === 1'b1) se_cnt++;
      check("wr_en", wr_en, e_wr);
      check("sof_err", sof_err, e_se);
      check("frame_done", frame_done, m_done);
      check("busy", busy, m_busy);
      check("pix_ready", pix.ready, m_busy && !m_done);
      if (e_wr) begin
         check("wr_addr", wr_addr, e_addr);
         check("wr_data", wr_data, d);
      end
   endtask

   task automatic run_pixels(input int n, input bit sof_first, input bit stall,
                             input bit addr_data, input bit rand_start);
      int got = 0;
      int iter = 0;
      logic [DW-1:0] d;
      while (got < n && iter < 20 * n + 20) begin
         d = addr_data ? DW'(got) : DW'($urandom);
         step(rand_start ? ($urandom_range(0, 7) == 0) : 1'b0,
              stall ? 1'($urandom_range(0, 1)) : 1'b1,
              sof_first && got == 0, d);
         if (m_acc) got++;
         iter++;
      end
      if (got < n) check("pixel_budget", got, n);
      pix.valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_ready"}, pix.ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_sof_err"}, sof_err, 0);
   endtask

   initial begin
      pix.valid = 1'b0; pix.sof = 1'b0; pix.data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // full frame back-to-back, data = address
      wr_cnt = 0; fd_cnt = 0;
      step(1, 0, 0, 0);
      run_pixels(N, 1, 0, 1, 0);
      check("full_wr_count", wr_cnt, N);
      check("full_last_addr", wr_addr, N - 1);
      check("full_fd_count", fd_cnt, 1);
      step(0, 0, 0, 0);

      // pre-SOF discard, then a stalled frame with stray starts; start in DONE ignored
      wr_cnt = 0; fd_cnt = 0;
      step(1, 0, 0, 0);
      run_pixels(5, 0, 0, 0, 1);
      check("discard_wr_count", wr_cnt, 0);
      run_pixels(N, 1, 1, 0, 1);
      check("stall_wr_count", wr_cnt, N);
      check("stall_last_addr", wr_addr, N - 1);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      check("stall_fd_count", fd_cnt, 1);

      // mid-frame SOF on the 61st pixel
      wr_cnt = 0; fd_cnt = 0; se_cnt = 0;
      step(1, 0, 0, 0);
      run_pixels(60, 1, 0, 0, 0);
      run_pixels(N, 1, 0, 0, 0);
      check("resync_sof_err_count", se_cnt, 1);
      check("resync_wr_count", wr_cnt, 60 + N);
      check("resync_fd_count", fd_cnt, 1);
      step(0, 0, 0, 0);

      // asynchronous reset mid-frame just after address 50 was written
      step(1, 0, 0, 0);
      run_pixels(51, 1, 0, 0, 0);
      check("pre_reset_addr", wr_addr, 50);
      #3 rst = 1'b1;
      #1 check_all_zero("async_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      wr_cnt = 0; fd_cnt = 0;
      step(1, 0, 0, 0);
      run_pixels(N, 1, 1, 0, 0);
      check("post_reset_wr_count", wr_cnt, N);
      check("post_reset_fd_count", fd_cnt, 1);
      step(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
